// File: rtl/picoctrl_pkg.sv
// Shared types and constants for the picoctrl sequencer.
// Instruction word layout: {cond[3:0], op[1:0], reg[1:0], imm[7:0]}.
package picoctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [1:0] OP_JUMP  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [1:0] REG_OUT0 = 2'd0;
  localparam logic [1:0] REG_OUT1 = 2'd1;
  localparam logic [1:0] REG_OUT2 = 2'd2;
  localparam logic [1:0] REG_OUT3 = 2'd3;

  // cond[3] is the required polarity, cond[2:0] selects one of c0..c7
  localparam int COND_W       = 4;
  localparam int COND_POL_BIT = 3;
  localparam int COND_SEL_W   = 3;

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [1:0]        op;
    logic [1:0]        rsel;
    logic [7:0]        imm;
  } instr_t;

  localparam logic [15:0] NOP = 16'h8000;

  function automatic logic cond_match(input logic [7:0] cond_eff,
                                      input logic [COND_W-1:0] cond);
    return cond_eff[cond[COND_SEL_W-1:0]] == cond[COND_POL_BIT];
  endfunction

endpackage

// File: rtl/picoctrl_sequencer_sync2.sv
// Two-flop synchronizer for the external condition lines.
// Only instantiated when PICOCTRL_SYNC_COND_EN is defined.
module picoctrl_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // two-stage capture, both stages clear on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/picoctrl_sequencer.sv
// Tiny ROM-driven sequencer: fetch/execute of conditional write and jump.
// Optional feature macro: PICOCTRL_SYNC_COND_EN (synchronize cond_in).
//
// state    | meaning
// ST_IDLE  | halted, waiting for run
// ST_FETCH | rom_data at pc captured into ir
// ST_EXEC  | ir executed, pc advanced or jumped
module picoctrl_sequencer
  import picoctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [7:0]        cond_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  state_t            state, state_nxt;
  logic              fetch_en, exec_en;
  instr_t            ir;
  logic [7:0]        cond_eff;
  logic              match;
  logic [DATA_W-1:0] out_r [4];

`ifdef PICOCTRL_SYNC_COND_EN
  picoctrl_sync2 #(.W(8)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cond_in),
    .q     (cond_eff)
  );
`else
  assign cond_eff = cond_in;
`endif

  assign match    = cond_match(cond_eff, ir.cond);
  assign rom_addr = pc;
  assign busy     = (state != ST_IDLE);
  assign out0     = out_r[REG_OUT0];
  assign out1     = out_r[REG_OUT1];
  assign out2     = out_r[REG_OUT2];
  assign out3     = out_r[REG_OUT3];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next-state and phase strobes; an instruction in EXEC always finishes
  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    exec_en   = 1'b0;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        fetch_en  = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en   = 1'b1;
        state_nxt = run ? ST_FETCH : ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // instruction register, program counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      ir    <= NOP;
      out_r <= '{default: '0};
    end else begin
      if (fetch_en) ir <= rom_data;
      if (exec_en) begin
        pc <= pc + 1'b1;
        case (ir.op)
          OP_WRITE: if (match) out_r[ir.rsel] <= DATA_W'(ir.imm);
          OP_JUMP:  if (match) pc <= ADDR_W'(ir.imm);
          default:  ;
        endcase
      end
    end
  end

endmodule
